// File: rtl/soc_ifc_pkg.sv
// Shared types and defaults for the SoC interface fuse loader.
package soc_ifc_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        FETCH      = 3'd2,
        WRITE      = 3'd3,
        WR_DONE    = 3'd4,
        WAIT_LOCK  = 3'd5,
        DONE       = 3'd6,
        ERROR      = 3'd7
    } fuse_loader_state_e;

    localparam logic [11:0] FUSE_BASE_ADDR_DEFAULT = 12'h200;
    localparam logic [11:0] FUSE_DONE_ADDR_DEFAULT = 12'h3F0;
    localparam logic [31:0] FUSE_DONE_VALUE        = 32'h1;

    // Index width never collapses to zero, even for a single fuse word.
    function automatic int unsigned fuse_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_ifc_fuse_loader_if.sv
// Fuse-source read channel and register write channel of the fuse loader.
interface soc_ifc_fuse_loader_if #(
    parameter int unsigned IDXW = 4
);
    import soc_ifc_pkg::*;

    logic            otp_req;
    logic [IDXW-1:0] otp_idx;
    logic            otp_valid;
    logic [31:0]     otp_rdata;

    logic            wr_req;
    logic [11:0]     wr_addr;
    logic [31:0]     wr_data;
    logic            wr_ack;
    logic            wr_err;

    modport master (
        output otp_req, otp_idx,
        input  otp_valid, otp_rdata,
        output wr_req, wr_addr, wr_data,
        input  wr_ack, wr_err
    );

    modport slave (
        input  otp_req, otp_idx,
        output otp_valid, otp_rdata,
        input  wr_req, wr_addr, wr_data,
        output wr_ack, wr_err
    );

endinterface

// File: rtl/soc_ifc_fuse_loader_timer.sv
// Per-state wait timer for the fuse loader; only built with SOC_IFC_FUSE_LOADER_TIMEOUT_EN.
`ifdef SOC_IFC_FUSE_LOADER_TIMEOUT_EN
module soc_ifc_fuse_loader_timer
    import soc_ifc_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic count_en,
    output logic expired
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the last counted cycle so the state changes exactly at the limit.
    assign expired = count_en && (cnt_q >= (TIMEOUT_CYCLES - 16'd1));

endmodule
`endif

// File: rtl/soc_ifc_fuse_loader.sv
// Streams fuse words from the OTP source into the register block, then writes fuse-done.
// Optional per-wait timeout enabled by defining SOC_IFC_FUSE_LOADER_TIMEOUT_EN.
module soc_ifc_fuse_loader
    import soc_ifc_pkg::*;
#(
    parameter int unsigned NUM_FUSE_WORDS = 16,
    parameter logic [11:0] FUSE_BASE_ADDR = FUSE_BASE_ADDR_DEFAULT,
    parameter logic [11:0] FUSE_DONE_ADDR = FUSE_DONE_ADDR_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
    localparam int unsigned IDXW = fuse_idx_width(NUM_FUSE_WORDS)
) (
    input  logic                         clk,
    input  logic                         cptra_rst_b,
    input  logic                         start,
    input  logic                         ready_for_fuses,
    soc_ifc_fuse_loader_if.master        bus,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [5:0]                   words_written
);

    typedef fuse_loader_state_e state_e;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_FUSE_WORDS - 1);

    if ((NUM_FUSE_WORDS < 1) || (NUM_FUSE_WORDS > 32) || (TIMEOUT_CYCLES == 16'd0)) begin : g_bad_params
        $error("soc_ifc_fuse_loader: parameter out of range");
    end

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic [5:0]      words_written_q, words_written_d;
    logic            in_wait;
    logic            tmo_expired;

    assign in_wait = (state_q == WAIT_READY) || (state_q == FETCH) || (state_q == WRITE) ||
                     (state_q == WR_DONE)    || (state_q == WAIT_LOCK);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        data_d          = data_q;
        words_written_d = words_written_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_READY;
            end
            WAIT_READY: begin
                if (ready_for_fuses) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (!ready_for_fuses) begin
                    state_d = ERROR;
                end else if (bus.otp_valid) begin
                    data_d  = bus.otp_rdata;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A lock drop outranks a same-cycle ack.
                if (!ready_for_fuses) begin
                    state_d = ERROR;
                end else if (bus.wr_ack) begin
                    if (bus.wr_err) begin
                        state_d = ERROR;
                    end else begin
                        words_written_d = words_written_q + 6'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = WR_DONE;
                        end else begin
                            idx_d   = idx_q + IDXW'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            WR_DONE: begin
                if (!ready_for_fuses) begin
                    state_d = ERROR;
                end else if (bus.wr_ack) begin
                    state_d = bus.wr_err ? ERROR : WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (!ready_for_fuses) state_d = DONE;
            end
            DONE, ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tmo_expired && (state_d == state_q)) state_d = ERROR;
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            data_q          <= '0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            data_q          <= data_d;
            words_written_q <= words_written_d;
        end
    end

`ifdef SOC_IFC_FUSE_LOADER_TIMEOUT_EN
    soc_ifc_fuse_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (cptra_rst_b),
        .restart  (state_d != state_q),
        .count_en (in_wait),
        .expired  (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Every output decodes from registered state, so reset clears them asynchronously.
    always_comb begin
        bus.otp_req   = (state_q == FETCH);
        bus.otp_idx   = (state_q == FETCH) ? idx_q : '0;
        bus.wr_req    = (state_q == WRITE) || (state_q == WR_DONE);
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        if (state_q == WRITE) begin
            bus.wr_addr = FUSE_BASE_ADDR + 12'({idx_q, 2'b00});
            bus.wr_data = data_q;
        end else if (state_q == WR_DONE) begin
            bus.wr_addr = FUSE_DONE_ADDR;
            bus.wr_data = FUSE_DONE_VALUE;
        end
        busy          = in_wait;
        done          = (state_q == DONE);
        error         = (state_q == ERROR);
        words_written = words_written_q;
    end

endmodule

// File: tb/tb_soc_ifc_fuse_loader.sv
// Randomized self-checking bench for soc_ifc_fuse_loader (4 fuse words, timeout limit 16).
module tb_soc_ifc_fuse_loader;

    localparam int NW = 4;

    logic       clk = 1'b0;
    logic       cptra_rst_b;
    logic       start;
    logic       ready_for_fuses;
    logic       busy, done, error;
    logic [5:0] words_written;

    soc_ifc_fuse_loader_if #(.IDXW(2)) bus ();

    soc_ifc_fuse_loader #(
        .NUM_FUSE_WORDS (NW),
        .FUSE_BASE_ADDR (12'h200),
        .FUSE_DONE_ADDR (12'h3F0),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .clk             (clk),
        .cptra_rst_b     (cptra_rst_b),
        .start           (start),
        .ready_for_fuses (ready_for_fuses),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .words_written   (words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [31:0] fuse [NW];
    logic [11:0] obs_addr [$];
    logic [31:0] obs_data [$];
    logic [11:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          exp_ww;
    bit          exp_done, exp_err;
    int          idx_errs, stable_errs;
    bit          drop_fall_ok;

    // Reference: what the register block should see, from the fuse contents and fault plan.
    task automatic build_expected(input int err_at, input int drop_at);
        exp_addr.delete(); exp_data.delete();
        exp_done = 0; exp_err = 0; exp_ww = 0;
        for (int k = 0; k < NW; k++) begin
            if (k == drop_at) begin exp_err = 1; exp_ww = k; return; end
            exp_addr.push_back(12'(12'h200 + 4 * k));
            exp_data.push_back(fuse[k]);
            if (k == err_at) begin exp_err = 1; exp_ww = k; return; end
        end
        exp_addr.push_back(12'h3F0);
        exp_data.push_back(32'h1);
        exp_done = 1; exp_ww = NW;
    endtask

    task automatic new_fuses();
        for (int i = 0; i < NW; i++) fuse[i] = $urandom;
        obs_addr.delete(); obs_data.delete();
        idx_errs = 0; stable_errs = 0; drop_fall_ok = 0;
    endtask

    task automatic do_reset();
        start = 0; ready_for_fuses = 1;
        bus.otp_valid = 0; bus.otp_rdata = '0; bus.wr_ack = 0; bus.wr_err = 0;
        cptra_rst_b = 0;
        repeat (3) @(negedge clk);
        cptra_rst_b = 1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    // Behaves as OTP source, register block and boot sequencer; records every acked write.
    task automatic serve(input int max_cyc, input int otp_lat, input int ack_lat,
                         input int err_at, input int drop_at, input bit stop_at_done_req,
                         output bit hit_bound);
        int otp_wait = 0, wr_wait = 0, ordinal = 0;
        bit lock = 0, drop_pend = 0;
        logic [11:0] a0 = '0;
        logic [31:0] d0 = '0;
        hit_bound = 1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            bus.otp_valid = 0; bus.wr_ack = 0; bus.wr_err = 0;
            if (drop_pend) begin drop_pend = 0; drop_fall_ok = (bus.wr_req === 1'b0); end
            if (done || error) begin hit_bound = 0; break; end
            if (stop_at_done_req && bus.wr_req && bus.wr_addr == 12'h3F0) begin hit_bound = 0; break; end
            if (lock && busy && !bus.wr_req) ready_for_fuses = 0;
            if (bus.otp_req) begin
                if (bus.otp_idx !== 2'(ordinal)) idx_errs++;
                otp_wait++;
                if (otp_wait > otp_lat) begin
                    bus.otp_valid = 1; bus.otp_rdata = fuse[bus.otp_idx]; otp_wait = 0;
                end
            end
            if (bus.wr_req) begin
                if (wr_wait == 0) begin a0 = bus.wr_addr; d0 = bus.wr_data; end
                else if (bus.wr_addr !== a0 || bus.wr_data !== d0) stable_errs++;
                wr_wait++;
                if (ordinal == drop_at && wr_wait == 1) begin
                    ready_for_fuses = 0; drop_pend = 1;
                end else if (wr_wait > ack_lat) begin
                    bus.wr_ack = 1; bus.wr_err = (ordinal == err_at);
                    obs_addr.push_back(a0); obs_data.push_back(d0);
                    if (a0 == 12'h3F0 && ordinal != err_at) lock = 1;
                    ordinal++; wr_wait = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        start = 0; ready_for_fuses = 1;
        bus.otp_valid = 0; bus.otp_rdata = '0; bus.wr_ack = 0; bus.wr_err = 0;
        cptra_rst_b = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.otp_req, bus.otp_idx, bus.wr_req, bus.wr_addr, bus.wr_data, busy, done, error} !== '0)
            $display("FAIL reset_outputs: got req/idx/wr=%b/%0d/%b addr=%h data=%h b/d/e=%b%b%b, want all 0",
                     bus.otp_req, bus.otp_idx, bus.wr_req, bus.wr_addr, bus.wr_data, busy, done, error);
        else passed++;
        checks++;
        if (words_written !== 6'd0) $display("FAIL reset_words: got %0d want 0", words_written);
        else passed++;
    endtask

    task automatic test_normal_load();
        bit tmo;
        do_reset(); new_fuses(); build_expected(-1, -1);
        pulse_start();
        serve(400, $urandom_range(0, 3), 1, -1, -1, 0, tmo);
        checks++; if (tmo) $display("FAIL normal_bound: got timeout want finish"); else passed++;
        checks++;
        if (obs_addr.size() != exp_addr.size())
            $display("FAIL normal_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        else passed++;
        foreach (exp_addr[i]) begin
            checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL normal_wr%0d: got %h/%h want %h/%h", i,
                         (i < obs_addr.size()) ? obs_addr[i] : 12'h0,
                         (i < obs_data.size()) ? obs_data[i] : 32'h0, exp_addr[i], exp_data[i]);
            else passed++;
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || words_written !== 6'(exp_ww))
            $display("FAIL normal_status: got d/e/b=%b%b%b ww=%0d want 100 ww=%0d",
                     done, error, busy, words_written, exp_ww);
        else passed++;
        checks++;
        if (idx_errs != 0 || stable_errs != 0)
            $display("FAIL normal_protocol: got idx_errs=%0d unstable=%0d want 0/0", idx_errs, stable_errs);
        else passed++;
        pulse_start();
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || bus.wr_req !== 1'b0 || bus.otp_req !== 1'b0)
            $display("FAIL done_terminal: got d/wr/otp=%b%b%b want 100", done, bus.wr_req, bus.otp_req);
        else passed++;
    endtask

    task automatic test_late_ready();
        bit tmo;
        int early = 0;
        do_reset(); new_fuses(); build_expected(-1, -1);
        ready_for_fuses = 0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.otp_req !== 1'b0) early++;
        end
        checks++; if (early != 0) $display("FAIL late_early_req: got %0d cycles want 0", early); else passed++;
        ready_for_fuses = 1;
        @(negedge clk);
        checks++;
        if (bus.otp_req !== 1'b1 || bus.otp_idx !== 2'd0)
            $display("FAIL late_first_req: got req=%b idx=%0d want 1/0", bus.otp_req, bus.otp_idx);
        else passed++;
        serve(400, $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, 0, tmo);
        checks++;
        if (tmo || done !== 1'b1 || words_written !== 6'd4 || obs_addr.size() != exp_addr.size())
            $display("FAIL late_complete: got tmo=%b done=%b ww=%0d writes=%0d want 0/1/4/%0d",
                     tmo, done, words_written, obs_addr.size(), exp_addr.size());
        else passed++;
    endtask

    task automatic test_write_error();
        bit tmo;
        do_reset(); new_fuses(); build_expected(2, -1);
        pulse_start();
        serve(400, $urandom_range(0, 3), $urandom_range(0, 3), 2, -1, 0, tmo);
        checks++;
        if (tmo || error !== 1'b1 || done !== 1'b0 || words_written !== 6'(exp_ww))
            $display("FAIL werr_status: got tmo=%b e=%b d=%b ww=%0d want 0/1/0/%0d",
                     tmo, error, done, words_written, exp_ww);
        else passed++;
        checks++;
        if (obs_addr.size() != exp_addr.size() || obs_addr[obs_addr.size()-1] === 12'h3F0)
            $display("FAIL werr_writes: got %0d writes last=%h want %0d, none to 3f0",
                     obs_addr.size(), obs_addr[obs_addr.size()-1], exp_addr.size());
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || bus.wr_req !== 1'b0 || bus.otp_req !== 1'b0)
            $display("FAIL werr_terminal: got e/wr/otp=%b%b%b want 100", error, bus.wr_req, bus.otp_req);
        else passed++;
    endtask

    task automatic test_lock_drop();
        bit tmo;
        do_reset(); new_fuses(); build_expected(-1, 1);
        pulse_start();
        serve(400, $urandom_range(0, 3), $urandom_range(0, 3), -1, 1, 0, tmo);
        checks++;
        if (!drop_fall_ok) $display("FAIL drop_wr_fall: got wr_req still high want 0 next cycle");
        else passed++;
        checks++;
        if (tmo || error !== 1'b1 || words_written !== 6'(exp_ww) || obs_addr.size() != exp_addr.size())
            $display("FAIL drop_status: got tmo=%b e=%b ww=%0d writes=%0d want 0/1/%0d/%0d",
                     tmo, error, words_written, obs_addr.size(), exp_ww, exp_addr.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit tmo;
        do_reset(); new_fuses();
        pulse_start();
        serve(400, $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, 1, tmo);
        checks++;
        if (tmo || bus.wr_req !== 1'b1 || bus.wr_addr !== 12'h3F0)
            $display("FAIL rstmid_reach: got tmo=%b wr=%b addr=%h want 0/1/3f0", tmo, bus.wr_req, bus.wr_addr);
        else passed++;
        cptra_rst_b = 0;
        #1;
        checks++;
        if ({bus.otp_req, bus.wr_req, bus.wr_addr, bus.wr_data, busy, done, error, words_written} !== '0)
            $display("FAIL rstmid_async: got wr=%b addr=%h data=%h b/d/e=%b%b%b ww=%0d want all 0",
                     bus.wr_req, bus.wr_addr, bus.wr_data, busy, done, error, words_written);
        else passed++;
        @(negedge clk);
        cptra_rst_b = 1;
        new_fuses(); build_expected(-1, -1);
        pulse_start();
        serve(400, $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, 0, tmo);
        checks++;
        if (tmo || obs_addr.size() != exp_addr.size() || obs_addr[0] !== 12'h200 || obs_data[0] !== fuse[0])
            $display("FAIL rstmid_reload: got tmo=%b writes=%0d first=%h/%h want 0/%0d 200/%h",
                     tmo, obs_addr.size(), obs_addr[0], obs_data[0], exp_addr.size(), fuse[0]);
        else passed++;
        checks++;
        if (done !== 1'b1 || words_written !== 6'd4)
            $display("FAIL rstmid_done: got d=%b ww=%0d want 1/4", done, words_written);
        else passed++;
    endtask

    task automatic test_random_loads();
        bit tmo;
        int err_at, drop_at, bad;
        for (int it = 0; it < 6; it++) begin
            err_at  = int'($urandom_range(0, 5)) - 1;
            drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
            do_reset(); new_fuses(); build_expected(err_at, drop_at);
            pulse_start();
            serve(600, $urandom_range(0, 4), $urandom_range(0, 4), err_at, drop_at, 0, tmo);
            bad = 0;
            foreach (exp_addr[i])
                if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
            checks++;
            if (tmo || bad != 0 || obs_addr.size() != exp_addr.size() || done !== exp_done ||
                error !== exp_err || words_written !== 6'(exp_ww) || idx_errs != 0 || stable_errs != 0)
                $display("FAIL random%0d(err=%0d drop=%0d): got tmo=%b badwr=%0d n=%0d d/e=%b%b ww=%0d idx=%0d uns=%0d want n=%0d d/e=%b%b ww=%0d",
                         it, err_at, drop_at, tmo, bad, obs_addr.size(), done, error, words_written,
                         idx_errs, stable_errs, exp_addr.size(), exp_done, exp_err, exp_ww);
            else passed++;
        end
    endtask

`ifdef SOC_IFC_FUSE_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (error) break;
            if (bus.otp_req) n++;
        end
        checks++;
        if (n != 16 || error !== 1'b1)
            $display("FAIL timeout_fetch: got %0d fetch cycles error=%b want 16/1", n, error);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_normal_load();
        test_late_ready();
        test_write_error();
        test_lock_drop();
        test_reset_mid();
        test_random_loads();
`ifdef SOC_IFC_FUSE_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/soc_ifc_fuse_loader.md
SOC_IFC_FUSE_LOADER -- requirements
Module: soc_ifc_fuse_loader

Interface
REQ-001 NUM_FUSE_WORDS, 16: fuse words streamed per load, range 1..32; IDXW = $clog2(NUM_FUSE_WORDS), minimum 1.
REQ-002 FUSE_BASE_ADDR, 12'h200: register address of fuse word 0.
REQ-003 FUSE_DONE_ADDR, 12'h3F0: register address of the fuse-done register.
REQ-004 TIMEOUT_CYCLES, 1024: per-wait timeout limit, 16-bit, used only under the REQ-029 macro.
REQ-005 clk  in  1  sole clock; all flops rise-edge.
REQ-006 cptra_rst_b  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle load request.
REQ-008 ready_for_fuses  in  1  boot sequencer open for fuse writes.
REQ-009 otp_req  out  1, otp_idx  out  IDXW  fuse-source read request and word index.
REQ-010 otp_valid  in  1, otp_rdata  in  32  read return, valid for one cycle.
REQ-011 wr_req  out  1, wr_addr  out  12, wr_data  out  32  register write request.
REQ-012 wr_ack  in  1, wr_err  in  1  write completion and error; wr_err is sampled only with wr_ack.
REQ-013 busy, done, error  out  1 each  status; words_written  out  6  count of acked fuse-word writes.

Function
REQ-014 States: IDLE, WAIT_READY, FETCH, WRITE, WR_DONE, WAIT_LOCK, DONE, ERROR; held in a state_e enum.
REQ-015 IDLE -> WAIT_READY when start=1; start is ignored in every other state.
REQ-016 WAIT_READY -> FETCH on the first cycle ready_for_fuses=1; word index idx=0.
REQ-017 FETCH drives otp_req=1 and otp_idx=idx until the otp_valid cycle; on that cycle it latches otp_rdata and goes to WRITE.
REQ-018 WRITE drives wr_req=1, wr_addr=FUSE_BASE_ADDR+4*idx and wr_data=latched word; address and data stay stable until the wr_req&wr_ack cycle.
REQ-019 WRITE on ack with wr_err=0: words_written increments; if idx=NUM_FUSE_WORDS-1 go to WR_DONE, else idx+1 and go to FETCH.
REQ-020 WR_DONE drives wr_req=1, wr_addr=FUSE_DONE_ADDR, wr_data=32'h1; on ack with wr_err=0 go to WAIT_LOCK.
REQ-021 WAIT_LOCK -> DONE on the first cycle ready_for_fuses=0.
REQ-022 Any ack with wr_err=1 -> ERROR; the transaction is not counted.
REQ-023 ready_for_fuses=0 while in FETCH, WRITE or WR_DONE -> ERROR; an ack in the same cycle is ignored.
REQ-024 DONE and ERROR are terminal until reset; wr_req=0 and otp_req=0 there.
REQ-025 busy=1 in WAIT_READY through WAIT_LOCK; done=1 only in DONE; error=1 only in ERROR; all outputs are registered or decoded from state.
REQ-026 wr_req rises no earlier than the cycle after otp_valid, so there is at least one bubble per word.

Reset
REQ-027 On cptra_rst_b=0, without waiting for clk: state=IDLE, idx=0, words_written=0, latched data=0, and every output is 0.
REQ-028 Reset asserted mid-transaction drops wr_req and otp_req at once; there is no completion or retry after reset.

Configuration
REQ-029 With SOC_IFC_FUSE_LOADER_TIMEOUT_EN defined, a 16-bit counter clears on each state entry and counts cycles spent in WAIT_READY, FETCH, WRITE, WR_DONE and WAIT_LOCK; reaching TIMEOUT_CYCLES -> ERROR.
REQ-030 Without the macro, the counter is absent and every wait is unbounded.

Structure
REQ-031 soc_ifc_pkg holds the fuse_loader_state_e enum and the default FUSE_BASE_ADDR and FUSE_DONE_ADDR constants.
REQ-032 There is one sub-module, soc_ifc_fuse_loader_timer, the timeout counter; it is instantiated only under the macro.

Verification
REQ-033 Normal load: start, ready_for_fuses=1, NUM_FUSE_WORDS=4, wr_ack 2 cycles after each wr_req.
- Required: writes to 0x200, 0x204, 0x208, 0x20C with the returned data, then 0x3F0 with data 1.
- Then drop ready_for_fuses: done=1 and words_written=4.
REQ-034 Late ready: hold ready_for_fuses=0 for 50 cycles after start -> no otp_req before ready rises; otp_req is issued the cycle after ready rises.
REQ-035 Write error: wr_err=1 on the third word's ack -> error=1, words_written=2, and no write to 0x3F0.
REQ-036 Lock drop: drop ready_for_fuses mid-WRITE of word 1 -> ERROR, and wr_req falls the next cycle.
REQ-037 Reset mid-transaction: assert cptra_rst_b=0 during WR_DONE -> all outputs are 0 at once; a new start after release reloads from word 0.
REQ-038 Timeout (macro defined, TIMEOUT_CYCLES=16): never return otp_valid -> error=1 in the 17th cycle of FETCH.
